top_level_vec: RTL and testbench

- Board-level top for the ROM/RAM vector-processing demo.
- Two constant 16-element ROM vectors A and B feed a sequencer. It writes the element-wise products into a 16-entry RAM and accumulates their sum (dot product).
- Switches select what is shown: any ROM/RAM element or the accumulator, as 4 hex digits on a multiplexed 4-digit seven-segment display.

---
 rtl/top_level_vec.sv | 174 +++++++++++++++++
 tb/tb_top_level_vec.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/top_level_vec.sv
// Board top: ROM vectors A,B -> element-wise products into RAM plus running dot product.
// Latency: a run takes 16 cycles after a 2-3 cycle start synchroniser; the display is combinational on sw.
// Backpressure: none; start edges are ignored while a run is in progress.
module top_level_vec #(
  parameter int N_ELEM       = 16,
  parameter int REFRESH_BITS = 18
) (
  input  logic        clk,
  input  logic        btnC,
  input  logic [15:0] sw,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int IW = $clog2(N_ELEM);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  logic [1:0]              rst_sync_q;
  logic                    rst_n;
  logic [1:0]              start_sync_q;
  logic                    start_prev_q;
  logic                    start_pulse;
  state_t                  state_q, state_d;
  logic [IW-1:0]           k_q, k_d;
  logic [15:0]             acc_q, acc_d;
  logic                    done_q, done_d;
  logic                    ram_we;
  logic [15:0]             prod;
  logic [15:0]             ram [N_ELEM];
  logic [REFRESH_BITS-1:0] refresh_q;
  logic [1:0]              digit;
  logic [IW-1:0]           idx;
  logic [15:0]             view_val;
  logic [3:0]              nibble;
  logic                    sw_unused;

  // Constant ROM contents: A[k] = k+1, B[k] = N_ELEM-k.
  function automatic logic [7:0] rom_a(input logic [IW-1:0] i);
    return 8'(i) + 8'd1;
  endfunction

  function automatic logic [7:0] rom_b(input logic [IW-1:0] i);
    return 8'(N_ELEM) - 8'(i);
  endfunction

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign rst_n       = rst_sync_q[1];
  assign start_pulse = start_sync_q[1] & ~start_prev_q;
  assign prod        = {8'h00, rom_a(k_q)} * {8'h00, rom_b(k_q)};
  assign idx         = sw[IW-1:0];
  assign digit       = refresh_q[REFRESH_BITS-1 -: 2];
  assign sw_unused   = ^sw[14:6];

  // Reset asserts immediately with btnC, releases two clocks later in the clk domain.
  always_ff @(posedge clk or negedge btnC) begin
    if (!btnC) rst_sync_q <= 2'b00;
    else       rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  // Start switch synchroniser plus previous-value register for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_sync_q <= 2'b00;
      start_prev_q <= 1'b0;
    end else begin
      start_sync_q <= {start_sync_q[0], sw[15]};
      start_prev_q <= start_sync_q[1];
    end
  end

  // Sequencer state, index, accumulator and done flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      acc_q   <= 16'h0000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
    end
  end

  // Next-state: a start edge (re)launches a run from IDLE or DONE; RUN walks all N_ELEM elements.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    done_d  = done_q;
    ram_we  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_pulse) begin
          state_d = S_RUN;
          k_d     = '0;
          acc_d   = 16'h0000;
          done_d  = 1'b0;
        end
      end
      S_RUN: begin
        ram_we = 1'b1;
        acc_d  = acc_q + prod;
        k_d    = k_q + IW'(1);
        if (k_q == IW'(N_ELEM - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Product RAM: synchronous write, deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram[k_q] <= prod;
  end

  // Free-running display refresh counter; its top two bits pick the digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) refresh_q <= '0;
    else        refresh_q <= refresh_q + REFRESH_BITS'(1);
  end

  // View select: RAM contents are only meaningful once a run has completed.
  always_comb begin
    view_val = 16'h0000;
    case (sw[5:4])
      2'b00:   view_val = {8'h00, rom_a(idx)};
      2'b01:   view_val = {8'h00, rom_b(idx)};
      2'b10:   view_val = done_q ? ram[idx] : 16'h0000;
      default: view_val = acc_q;
    endcase
  end

  // Digit multiplexer: one active-low anode and its nibble per refresh phase.
  always_comb begin
    an     = 4'b1110;
    nibble = view_val[3:0];
    case (digit)
      2'd1: begin an = 4'b1101; nibble = view_val[7:4];   end
      2'd2: begin an = 4'b1011; nibble = view_val[11:8];  end
      2'd3: begin an = 4'b0111; nibble = view_val[15:12]; end
      default: begin an = 4'b1110; nibble = view_val[3:0]; end
    endcase
  end

  assign seg = hex_to_seg(nibble);

endmodule

// File: tb/tb_top_level_vec.sv
// Bench for top_level_vec: random views checked against a vector-level model of the demo.
// Display values are read back digit by digit through the multiplexed an/seg outputs.
module tb_top_level_vec;

  logic        clk = 1'b0;
  logic        btnC;
  logic [15:0] sw;
  logic [3:0]  an;
  logic [6:0]  seg;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: what the board should hold after the operations so far.
  logic [15:0] ram_m [16];
  logic [15:0] acc_m;
  logic        done_m;

  always #5 clk = ~clk;

  top_level_vec #(.N_ELEM(16), .REFRESH_BITS(4)) dut (
    .clk  (clk),
    .btnC (btnC),
    .sw   (sw),
    .an   (an),
    .seg  (seg)
  );

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[n];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // A full run leaves every product in RAM and their sum in the accumulator.
  task automatic model_run_complete();
    int sum = 0;
    for (int k = 0; k < 16; k++) begin
      ram_m[k] = 16'((k + 1) * (16 - k));
      sum += (k + 1) * (16 - k);
    end
    acc_m  = 16'(sum);
    done_m = 1'b1;
  endtask

  function automatic logic [15:0] model_view(input logic [1:0] v, input logic [3:0] i);
    case (v)
      2'd0:    return 16'(i) + 16'd1;
      2'd1:    return 16'd16 - 16'(i);
      2'd2:    return done_m ? ram_m[i] : 16'h0000;
      default: return acc_m;
    endcase
  endfunction

  function automatic int an_digit(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // Watch the display until every digit has been shown once; check each against exp.
  task automatic show_check(input string tag, input logic [15:0] exp);
    logic [3:0] seen = 4'h0;
    int d;
    for (int c = 0; c < 40 && seen != 4'hF; c++) begin
      @(negedge clk);
      d = an_digit(an);
      if (d < 0) chk({tag, "_an"}, {28'h0, an}, 32'h0000000E);
      else if (!seen[d]) begin
        seen[d] = 1'b1;
        chk($sformatf("%s_d%0d", tag, d), {25'h0, seg}, {25'h0, hex7(exp[4*d +: 4])});
      end
    end
    chk({tag, "_seen"}, {28'h0, seen}, 32'h0000000F);
  endtask

  task automatic rand_views(input int n);
    logic [1:0] v;
    logic [3:0] i;
    for (int r = 0; r < n; r++) begin
      v = 2'($urandom_range(0, 3));
      i = 4'($urandom_range(0, 15));
      sw[5:0] = {v, i};
      show_check($sformatf("view%0d_i%0d", v, i), model_view(v, i));
    end
  endtask

  task automatic start_edge();
    sw[15] = 1'b0;
    repeat (3) @(negedge clk);
    sw[15] = 1'b1;
  endtask

  initial begin
    logic [3:0] seq [$];
    logic [3:0] prev;
    logic [3:0] exp_seq [5];
    int bad;
    int d;
    int abort_at;

    btnC   = 1'b1;
    sw     = 16'h0000;
    done_m = 1'b0;
    acc_m  = 16'h0000;
    foreach (ram_m[k]) ram_m[k] = 16'h0000;
    #1 btnC = 1'b0;
    #7;
    chk("rst_an", {28'h0, an}, 32'h0000000E);
    chk("rst_seg", {25'h0, seg}, {25'h0, hex7(4'h1)});
    #4 btnC = 1'b1;

    // Digit scan after reset release.
    exp_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    prev = an;
    seq.push_back(prev);
    for (int c = 0; c < 40 && seq.size() < 5; c++) begin
      @(negedge clk);
      if (an != prev) begin
        prev = an;
        seq.push_back(prev);
      end
    end
    chk("scan_len", seq.size(), 5);
    for (int j = 0; j < 5 && j < seq.size(); j++)
      chk($sformatf("scan_%0d", j), {28'h0, seq[j]}, {28'h0, exp_seq[j]});
    show_check("rst_view", model_view(2'd0, 4'd0));

    sw[5:0] = {2'b01, 4'd3};
    show_check("rom_b3", model_view(2'd1, 4'd3));
    sw[5:0] = {2'b10, 4'd7};
    show_check("ram_pre", model_view(2'd2, 4'd7));
    rand_views(6);

    // Full run with a second start edge inside RUN and sw[15] then held high.
    sw[5:4] = 2'b11;
    start_edge();
    model_run_complete();
    repeat (5) @(negedge clk);
    sw[15] = 1'b0;
    repeat (5) @(negedge clk);
    sw[15] = 1'b1;
    repeat (12) @(negedge clk);
    bad = 0;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      d = an_digit(an);
      if (d < 0 || seg !== hex7(acc_m[4*d +: 4])) bad++;
    end
    chk("acc_hold", bad, 0);
    show_check("acc_run", model_view(2'd3, 4'd0));
    sw[5:0] = {2'b10, 4'd0};
    show_check("ram_i0", model_view(2'd2, 4'd0));
    sw[5:0] = {2'b10, 4'd7};
    show_check("ram_i7", model_view(2'd2, 4'd7));
    sw[5:0] = {2'b10, 4'd15};
    show_check("ram_i15", model_view(2'd2, 4'd15));
    rand_views(10);

    // Reset in the middle of a run, then a fresh run.
    for (int it = 0; it < 2; it++) begin
      abort_at = (it == 0) ? 10 : $urandom_range(4, 17);
      sw[5:4] = 2'b11;
      start_edge();
      repeat (abort_at) @(negedge clk);
      btnC   = 1'b0;
      sw[15] = 1'b0;
      acc_m  = 16'h0000;
      done_m = 1'b0;
      #10;
      @(negedge clk);
      btnC = 1'b1;
      repeat (4) @(negedge clk);
      show_check($sformatf("abort%0d_acc", it), model_view(2'd3, 4'd0));
      sw[5:0] = {2'b10, 4'd5};
      show_check($sformatf("abort%0d_ram", it), model_view(2'd2, 4'd5));
      rand_views(3);

      sw[5:4] = 2'b11;
      start_edge();
      repeat (30) @(negedge clk);
      model_run_complete();
      show_check($sformatf("rerun%0d_acc", it), model_view(2'd3, 4'd0));
      rand_views(5);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
